paddle_ctrl: RTL

Converts debounced button events into a clamped paddle vertical position for the pingpong game. Sits directly downstream of the button debouncers (one instance per player): consumes each button's debounced level and press pulse, and produces the paddle Y coordinate consumed by the renderer and collision logic. A single press gives one step. Holding a button gives auto-repeat: an initial delay, then a fixed frame rate.

---
 rtl/paddle_ctrl_if.sv | 29 ++
 rtl/paddle_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl_if.sv
// Paddle controller bus: debounced button inputs, game controls and paddle outputs.
// The master drives the controls and buttons; the slave (paddle_ctrl) drives the position.
interface paddle_ctrl_if #(
  parameter int Y_WIDTH = 10
);
  logic               frame_tick_i;
  logic               en_i;
  logic               recenter_i;
  logic               up_state_i;
  logic               up_press_i;
  logic               dn_state_i;
  logic               dn_press_i;
  logic [Y_WIDTH-1:0] paddle_y_o;
  logic               move_o;
  logic               at_top_o;
  logic               at_bottom_o;

  modport master (
    output frame_tick_i, en_i, recenter_i,
    output up_state_i, up_press_i, dn_state_i, dn_press_i,
    input  paddle_y_o, move_o, at_top_o, at_bottom_o
  );

  modport slave (
    input  frame_tick_i, en_i, recenter_i,
    input  up_state_i, up_press_i, dn_state_i, dn_press_i,
    output paddle_y_o, move_o, at_top_o, at_bottom_o
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Paddle controller: turns debounced button presses/holds into a clamped paddle Y.
// One step per valid press, then auto-repeat after REPEAT_DELAY frame ticks,
// every REPEAT_PERIOD ticks while the same single button stays held.
module paddle_ctrl #(
  parameter int Y_WIDTH       = 10,
  parameter int SCREEN_H      = 480,
  parameter int PADDLE_H      = 64,
  parameter int Y_INIT        = 208,
  parameter int STEP          = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 2
) (
  input  logic         clk,
  input  logic         arst_n,
  paddle_ctrl_if.slave bus
);

  localparam int Y_MAX   = SCREEN_H - PADDLE_H;
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [Y_WIDTH-1:0] Y_MAX_C     = Y_WIDTH'(Y_MAX);
  localparam logic [Y_WIDTH-1:0] Y_INIT_C    = Y_WIDTH'(Y_INIT);
  localparam logic [Y_WIDTH-1:0] STEP_C      = Y_WIDTH'(STEP);
  localparam logic [CNT_W-1:0]   DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]   PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic               TOP_INIT    = (Y_INIT == 0);
  localparam logic               BOT_INIT    = (Y_INIT == Y_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  // Unsigned step with saturation at 0 and Y_MAX; never wraps.
  function automatic logic [Y_WIDTH-1:0] step_y(input logic [Y_WIDTH-1:0] y, input logic dn);
    logic [Y_WIDTH-1:0] r;
    if (dn) begin
      if (y > (Y_MAX_C - STEP_C)) r = Y_MAX_C;
      else                        r = y + STEP_C;
    end else begin
      if (y < STEP_C) r = {Y_WIDTH{1'b0}};
      else            r = y - STEP_C;
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;        // latched direction: 1 = down, 0 = up
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic               move_q, move_d;
  logic               top_q, top_d;
  logic               bot_q, bot_d;

  dir_e req_s;
  logic up_valid_s;
  logic dn_valid_s;
  logic match_s;
  logic step_s;
  logic step_dn_s;

  // A press only counts when the opposite button is neither held nor pressed.
  assign up_valid_s = bus.up_press_i & ~bus.dn_state_i & ~bus.dn_press_i;
  assign dn_valid_s = bus.dn_press_i & ~bus.up_state_i & ~bus.up_press_i;
  assign match_s    = dir_q ? (req_s == DIR_DN) : (req_s == DIR_UP);

  // Requested direction from the held levels; both or neither held means none.
  always_comb begin
    req_s = DIR_NONE;
    if (bus.up_state_i && !bus.dn_state_i)      req_s = DIR_UP;
    else if (bus.dn_state_i && !bus.up_state_i) req_s = DIR_DN;
    else                                        req_s = DIR_NONE;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic, repeat counter and step requests.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    step_s    = 1'b0;
    step_dn_s = dir_q;
    if (!bus.en_i || bus.recenter_i) begin
      state_d = S_IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (up_valid_s || dn_valid_s) begin
            step_s    = 1'b1;
            step_dn_s = dn_valid_s;
            dir_d     = dn_valid_s;
            cnt_d     = {CNT_W{1'b0}};
            state_d   = S_DELAY;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DELAY: begin
          if (!match_s) begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
          end else if (bus.frame_tick_i) begin
            if (cnt_q == DELAY_LAST) begin
              step_s  = 1'b1;
              cnt_d   = {CNT_W{1'b0}};
              state_d = S_REPEAT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = S_DELAY;
          end
        end
        S_REPEAT: begin
          if (!match_s) begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
          end else if (bus.frame_tick_i) begin
            if (cnt_q == PERIOD_LAST) begin
              step_s = 1'b1;
              cnt_d  = {CNT_W{1'b0}};
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = S_REPEAT;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Output logic: new position (recenter wins over any step), move pulse and flags.
  always_comb begin
    y_d = y_q;
    if (bus.recenter_i)  y_d = Y_INIT_C;
    else if (step_s)     y_d = step_y(y_q, step_dn_s);
    else                 y_d = y_q;
    move_d = (y_d != y_q);
    top_d  = (y_d == {Y_WIDTH{1'b0}});
    bot_d  = (y_d == Y_MAX_C);
  end

  // Datapath registers: counter, latched direction, position and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q  <= {CNT_W{1'b0}};
      dir_q  <= 1'b0;
      y_q    <= Y_INIT_C;
      move_q <= 1'b0;
      top_q  <= TOP_INIT;
      bot_q  <= BOT_INIT;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      y_q    <= y_d;
      move_q <= move_d;
      top_q  <= top_d;
      bot_q  <= bot_d;
    end
  end

  assign bus.paddle_y_o  = y_q;
  assign bus.move_o      = move_q;
  assign bus.at_top_o    = top_q;
  assign bus.at_bottom_o = bot_q;

endmodule
